// File: rtl/usr_nbit_bh_if.sv
// usr_nbit_bh_if: bus bundle for the universal shift register.
// The master drives mode/data/burst requests. The slave (usr_nbit_bh)
// returns the stage contents, the serial outputs and burst status.
// state_dbg mirrors the burst FSM state: 0 IDLE, 1 RUN.
interface usr_nbit_bh_if #(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int CW = 4
);
  logic           en_in;
  logic [1:0]     mode_in;
  logic [W-1:0]   sr_in;
  logic [W-1:0]   sl_in;
  logic [N*W-1:0] p_in;
  logic           start_in;
  logic [CW-1:0]  cnt_in;
  logic [N*W-1:0] p_out;
  logic [W-1:0]   sr_out;
  logic [W-1:0]   sl_out;
  logic           busy_out;
  logic           done_out;
  logic           state_dbg;

  modport master (
    output en_in, mode_in, sr_in, sl_in, p_in, start_in, cnt_in,
    input  p_out, sr_out, sl_out, busy_out, done_out, state_dbg
  );

  modport slave (
    input  en_in, mode_in, sr_in, sl_in, p_in, start_in, cnt_in,
    output p_out, sr_out, sl_out, busy_out, done_out, state_dbg
  );
endinterface

// File: rtl/usr_nbit_bh.sv
// usr_nbit_bh: N-stage, W-bit-lane universal shift register with hold,
// shift right, shift left and parallel load, plus a counted burst engine.
// Optional feature macro: USR_ROTATE_EN (shifts rotate; sr_in/sl_in ignored).
// Lane k lives at p_out[k*W +: W]. Right shift moves lane k+1 into lane k.
// CW must satisfy 2**CW - 1 >= N so that a full-length burst can be requested.
//
// Burst handshake: start_in is a one-cycle request sampled only in IDLE, and
// only when mode_in selects a shift direction (01 or 10). The accepting edge
// latches the direction and cnt_in and performs no shift. busy_out is high
// while the burst runs. done_out pulses for exactly one cycle when the burst
// finishes, or right after acceptance when cnt_in is 0. A new request may be
// presented during the cycle in which done_out is high.
module usr_nbit_bh #(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int CW = 4
) (
  input  logic           clk,
  input  logic           reset_al_in,
  usr_nbit_bh_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int PW = N * W;
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t         state_q, state_d;
  logic           dir_q, dir_d;      // 0 = right, 1 = left
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  stages_q, stages_d;
  logic           done_q, done_d;
  logic [PW-1:0]  shr_v, shl_v;
  logic           start_ok;

`ifdef USR_ROTATE_EN
  // Rotate: the lane leaving one end re-enters at the other end.
  assign shr_v = {stages_q[W-1:0], stages_q[PW-1:W]};
  assign shl_v = {stages_q[PW-W-1:0], stages_q[PW-1 -: W]};
  logic unused_serial;
  assign unused_serial = ^{bus.sr_in, bus.sl_in};
`else
  // Plain shift: serial inputs enter and the outgoing lane is discarded.
  assign shr_v = {bus.sr_in, stages_q[PW-1:W]};
  assign shl_v = {stages_q[PW-W-1:0], bus.sl_in};
`endif

  // A burst request counts only when it names a shift direction.
  assign start_ok = bus.start_in && ((bus.mode_in == 2'b01) || (bus.mode_in == 2'b10));

  // Next-state, next-data and done pulse for the burst FSM and storage.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    stages_d = stages_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          dir_d = (bus.mode_in == 2'b10);
          cnt_d = bus.cnt_in;
          if (bus.cnt_in == CNT_ZERO) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else if (bus.en_in) begin
          case (bus.mode_in)
            2'b01:   stages_d = shr_v;
            2'b10:   stages_d = shl_v;
            2'b11:   stages_d = bus.p_in;
            default: stages_d = stages_q;
          endcase
        end
      end
      RUN: begin
        stages_d = dir_q ? shl_v : shr_v;
        cnt_d    = cnt_q - CNT_ONE;
        // A count at or below one ends the burst on this edge.
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, direction, storage and done registers.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      cnt_q    <= CNT_ZERO;
      stages_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      stages_q <= stages_d;
      done_q   <= done_d;
    end
  end

  assign bus.p_out     = stages_q;
  assign bus.sr_out    = stages_q[W-1:0];
  assign bus.sl_out    = stages_q[PW-1 -: W];
  assign bus.busy_out  = (state_q == RUN);
  assign bus.done_out  = done_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_usr_nbit_bh.sv
// tb_usr_nbit_bh: directed bench for usr_nbit_bh. Default build uses N=8, W=1.
// With USR_ROTATE_EN defined the bench switches to N=4, W=4 and the rotate tests.
module tb_usr_nbit_bh;
`ifdef USR_ROTATE_EN
  localparam int N = 4;
  localparam int W = 4;
`else
  localparam int N = 8;
  localparam int W = 1;
`endif
  localparam int CW = 4;
  localparam int PW = N * W;

  logic clk;
  logic reset_al_in;
  int   checks;
  int   failures;

  usr_nbit_bh_if #(.N(N), .W(W), .CW(CW)) bus ();

  usr_nbit_bh #(.N(N), .W(W), .CW(CW)) dut (
    .clk         (clk),
    .reset_al_in (reset_al_in),
    .bus         (bus)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en_in    = 1'b0;
    bus.mode_in  = 2'b00;
    bus.sr_in    = '0;
    bus.sl_in    = '0;
    bus.p_in     = '0;
    bus.start_in = 1'b0;
    bus.cnt_in   = '0;
  endtask

  task automatic do_reset();
    reset_al_in = 1'b0;
    step();
    step();
    reset_al_in = 1'b1;
  endtask

  task automatic load(input logic [PW-1:0] v);
    bus.en_in   = 1'b1;
    bus.mode_in = 2'b11;
    bus.p_in    = v;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++; if (bus.p_out !== '0) begin failures++; $display("FAIL reset_p_out: got %h required 0", bus.p_out); end
    checks++; if (bus.sr_out !== '0) begin failures++; $display("FAIL reset_sr_out: got %h required 0", bus.sr_out); end
    checks++; if (bus.sl_out !== '0) begin failures++; $display("FAIL reset_sl_out: got %h required 0", bus.sl_out); end
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", bus.busy_out); end
    checks++; if (bus.done_out !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", bus.done_out); end
    load({PW{1'b1}});
    checks++; if (bus.p_out !== {PW{1'b1}}) begin failures++; $display("FAIL reset_preload: got %h required all ones", bus.p_out); end
    // Assert reset between edges: outputs must clear without a clock edge.
    #2;
    reset_al_in = 1'b0;
    #1;
    checks++; if (bus.p_out !== '0) begin failures++; $display("FAIL reset_async: got %h required 0", bus.p_out); end
    step();
    reset_al_in = 1'b1;
  endtask

`ifndef USR_ROTATE_EN
  task automatic test_load_shift();
    load(8'hA5);
    checks++; if (bus.p_out !== 8'hA5) begin failures++; $display("FAIL load_a5: got %h required a5", bus.p_out); end
    checks++; if (bus.sl_out !== 1'b1) begin failures++; $display("FAIL load_sl_out: got %b required 1", bus.sl_out); end
    bus.en_in   = 1'b1;
    bus.mode_in = 2'b01;
    bus.sr_in   = 1'b0;
    step();
    idle_inputs();
    checks++; if (bus.p_out !== 8'h52) begin failures++; $display("FAIL shr_once: got %h required 52", bus.p_out); end
    checks++; if (bus.sr_out !== 1'b0) begin failures++; $display("FAIL shr_once_sr_out: got %b required 0", bus.sr_out); end
    // Left shift of 52 with sl_in=1 gives a5.
    bus.en_in   = 1'b1;
    bus.mode_in = 2'b10;
    bus.sl_in   = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.p_out !== 8'hA5) begin failures++; $display("FAIL shl_once: got %h required a5", bus.p_out); end
  endtask

  task automatic test_serial_fill();
    logic [7:0] seq;
    logic [7:0] exp_p [8];
    seq = 8'b0000_1101;  // bit i is the value presented on shift i+1
    exp_p = '{8'h80, 8'h40, 8'hA0, 8'hD0, 8'h68, 8'h34, 8'h1A, 8'h0D};
    load(8'h00);
    for (int i = 0; i < 8; i++) begin
      bus.en_in   = 1'b1;
      bus.mode_in = 2'b01;
      bus.sr_in   = seq[i];
      step();
      checks++; if (bus.p_out !== exp_p[i]) begin failures++; $display("FAIL fill_p_%0d: got %h required %h", i, bus.p_out, exp_p[i]); end
      checks++; if (bus.sr_out !== (i == 7 ? 1'b1 : 1'b0)) begin failures++; $display("FAIL fill_sr_out_%0d: got %b required %b", i, bus.sr_out, (i == 7)); end
    end
    idle_inputs();
    bus.mode_in = 2'b01;
    bus.sr_in   = 1'b1;
    step();
    checks++; if (bus.p_out !== 8'h0D) begin failures++; $display("FAIL hold_en0: got %h required 0d", bus.p_out); end
    bus.en_in   = 1'b1;
    bus.mode_in = 2'b00;
    step();
    idle_inputs();
    checks++; if (bus.p_out !== 8'h0D) begin failures++; $display("FAIL hold_mode0: got %h required 0d", bus.p_out); end
  endtask

  task automatic test_burst();
    load(8'h81);
    bus.start_in = 1'b1;
    bus.mode_in  = 2'b10;
    bus.cnt_in   = 4'd3;
    bus.sl_in    = 1'b0;
    step();  // accept edge: no shift
    checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL burst_busy_accept: got %b required 1", bus.busy_out); end
    checks++; if (bus.state_dbg !== 1'b1) begin failures++; $display("FAIL burst_state_run: got %b required 1", bus.state_dbg); end
    checks++; if (bus.p_out !== 8'h81) begin failures++; $display("FAIL burst_no_shift_accept: got %h required 81", bus.p_out); end
    // Requests, loads and mode changes during RUN must be ignored.
    bus.start_in = 1'b1;
    bus.mode_in  = 2'b11;
    bus.en_in    = 1'b1;
    bus.p_in     = 8'hFF;
    bus.cnt_in   = 4'd5;
    step();
    checks++; if (bus.p_out !== 8'h02) begin failures++; $display("FAIL burst_shift1: got %h required 02", bus.p_out); end
    checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL burst_busy1: got %b required 1", bus.busy_out); end
    bus.mode_in = 2'b01;
    step();
    checks++; if (bus.p_out !== 8'h04) begin failures++; $display("FAIL burst_shift2: got %h required 04", bus.p_out); end
    checks++; if (bus.done_out !== 1'b0) begin failures++; $display("FAIL burst_done_early: got %b required 0", bus.done_out); end
    step();
    idle_inputs();
    checks++; if (bus.p_out !== 8'h08) begin failures++; $display("FAIL burst_final: got %h required 08", bus.p_out); end
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL burst_busy_end: got %b required 0", bus.busy_out); end
    checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL burst_done: got %b required 1", bus.done_out); end
    // Back-to-back: new right burst of 1 accepted during the done cycle.
    bus.start_in = 1'b1;
    bus.mode_in  = 2'b01;
    bus.cnt_in   = 4'd1;
    bus.sr_in    = 1'b1;
    step();
    bus.start_in = 1'b0;
    bus.mode_in  = 2'b00;
    checks++; if (bus.done_out !== 1'b0) begin failures++; $display("FAIL b2b_done_clear: got %b required 0", bus.done_out); end
    checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b required 1", bus.busy_out); end
    step();
    idle_inputs();
    checks++; if (bus.p_out !== 8'h84) begin failures++; $display("FAIL b2b_shift: got %h required 84", bus.p_out); end
    checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b required 1", bus.done_out); end
    step();
    checks++; if (bus.done_out !== 1'b0) begin failures++; $display("FAIL b2b_done_single: got %b required 0", bus.done_out); end
  endtask

  task automatic test_cnt_zero();
    bus.start_in = 1'b1;
    bus.mode_in  = 2'b10;
    bus.cnt_in   = 4'd0;
    step();
    idle_inputs();
    checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL cnt0_done: got %b required 1", bus.done_out); end
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL cnt0_busy: got %b required 0", bus.busy_out); end
    checks++; if (bus.p_out !== 8'h84) begin failures++; $display("FAIL cnt0_p_out: got %h required 84", bus.p_out); end
    step();
    checks++; if (bus.done_out !== 1'b0) begin failures++; $display("FAIL cnt0_done_single: got %b required 0", bus.done_out); end
    // start with mode 11 is not a burst; the load still happens.
    bus.start_in = 1'b1;
    bus.mode_in  = 2'b11;
    bus.en_in    = 1'b1;
    bus.p_in     = 8'h3C;
    bus.cnt_in   = 4'd2;
    step();
    idle_inputs();
    checks++; if (bus.p_out !== 8'h3C) begin failures++; $display("FAIL start_mode3_load: got %h required 3c", bus.p_out); end
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL start_mode3_busy: got %b required 0", bus.busy_out); end
  endtask

  task automatic test_reset_mid_burst();
    bus.start_in = 1'b1;
    bus.mode_in  = 2'b01;
    bus.cnt_in   = 4'd5;
    bus.sr_in    = 1'b0;
    step();
    idle_inputs();
    step();
    checks++; if (bus.p_out !== 8'h1E) begin failures++; $display("FAIL mid_shift1: got %h required 1e", bus.p_out); end
    #2;
    reset_al_in = 1'b0;
    #1;
    checks++; if (bus.p_out !== 8'h00) begin failures++; $display("FAIL mid_reset_p: got %h required 00", bus.p_out); end
    checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b required 0", bus.busy_out); end
    reset_al_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (bus.done_out !== 1'b0 || bus.busy_out !== 1'b0) begin failures++; $display("FAIL mid_reset_quiet_%0d: got done=%b busy=%b required 0 0", i, bus.done_out, bus.busy_out); end
    end
  endtask
`else
  task automatic test_rotate();
    int waited;
    load(16'h1234);
    bus.start_in = 1'b1;
    bus.mode_in  = 2'b01;
    bus.cnt_in   = 4'd4;
    step();
    idle_inputs();
    waited = 0;
    while (bus.done_out !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL rot_timeout: got done=%b required 1 within 10 cycles", bus.done_out); end
    checks++; if (waited !== 4) begin failures++; $display("FAIL rot_latency: got %0d cycles required 4", waited); end
    checks++; if (bus.p_out !== 16'h1234) begin failures++; $display("FAIL rot_full: got %h required 1234", bus.p_out); end
    bus.start_in = 1'b1;
    bus.mode_in  = 2'b01;
    bus.cnt_in   = 4'd1;
    bus.sr_in    = 4'hF;
    step();
    idle_inputs();
    step();
    checks++; if (bus.p_out !== 16'h4123) begin failures++; $display("FAIL rot_right1: got %h required 4123", bus.p_out); end
    checks++; if (bus.done_out !== 1'b1) begin failures++; $display("FAIL rot_done: got %b required 1", bus.done_out); end
    bus.start_in = 1'b1;
    bus.mode_in  = 2'b10;
    bus.cnt_in   = 4'd1;
    bus.sl_in    = 4'hF;
    step();
    idle_inputs();
    step();
    checks++; if (bus.p_out !== 16'h1234) begin failures++; $display("FAIL rot_left1: got %h required 1234", bus.p_out); end
  endtask
`endif

  // Test sequence and final report.
  initial begin
    checks      = 0;
    failures    = 0;
    reset_al_in = 1'b0;
    idle_inputs();
    test_reset();
`ifndef USR_ROTATE_EN
    test_load_shift();
    test_serial_fill();
    test_burst();
    test_cnt_zero();
    test_reset_mid_burst();
`else
    test_rotate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usr_nbit_bh.md
# usr_nbit_bh

Parametrised universal shift register: N stages of W-bit lanes, with hold, shift-right, shift-left and parallel-load modes. A burst engine runs a counted sequence of shifts in one direction with a busy/done handshake. It supersedes the fixed serial-in/serial-out registers as the general storage/serialiser element in the register library, for serial links, delay lines and parallel/serial conversion.

## Interface
- N, 8, number of stages (N ≥ 2)
- W, 1, bits per stage (lane width, W ≥ 1)
- CW, 4, burst count width; must satisfy 2^CW − 1 ≥ N
- clk  input  1  rising-edge clock
- reset_al_in  input  1  asynchronous, active-low reset
- en_in  input  1  enables mode_in operations when idle
- mode_in  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- sr_in  input  W  serial input for right shift; enters stage N−1
- sl_in  input  W  serial input for left shift; enters stage 0
- p_in  input  N*W  parallel load data; stage k = p_in[k*W +: W]
- start_in  input  1  burst request
- cnt_in  input  CW  number of shifts in the burst
- p_out  output  N*W  all stages, same packing as p_in
- sr_out  output  W  stage 0 (right-shift serial output)
- sl_out  output  W  stage N−1 (left-shift serial output)
- busy_out  output  1  burst in progress
- done_out  output  1  one-cycle pulse at burst completion

## Operation
- Right shift: stage k ← stage k+1, stage N−1 ← sr_in. Left shift: stage k ← stage k−1, stage 0 ← sl_in. The whole lane moves together.
- IDLE, no burst accepted: on each edge with en_in=1, apply mode_in. With en_in=0 or mode 00, hold.
- Burst FSM states are IDLE and RUN, plus a direction register and a down-counter.
- Accept: in IDLE, start_in=1 with mode_in ∈ {01, 10}. Latch the direction and cnt_in. This edge performs no shift.
- Acceptance is independent of en_in. On the accept edge, start takes priority over the normal mode operation.
- start_in with mode 00 or 11 is ignored, and the normal mode operation still applies.
- cnt_in=0: remain IDLE. done_out=1 for the next cycle. busy_out stays 0 and no shift occurs.
- cnt_in=C>0: go to RUN. Each RUN edge shifts once in the latched direction, sampling sr_in/sl_in at that edge, and decrements the counter.
- The edge with counter=1 returns to IDLE and registers done_out=1.
- In RUN, mode_in, en_in, start_in and p_in are ignored.
- Reset at any time, including mid-burst: all stages 0, state IDLE, counter 0, busy_out=0, done_out=0.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Parallel load: p_out equals p_in from the cycle after the load edge.
- Serial latency: a value on sr_in at edge t appears on sr_out after edge t+N−1, i.e. N right shifts end to end. Left shift is symmetric.
- Burst of C>0 accepted at edge t: busy_out is high after edges t … t+C−1, shifts occur at edges t+1 … t+C, and done_out is high for exactly the cycle after edge t+C.
- A new start is accepted at edge t+C+1 or later, i.e. back-to-back with the done pulse.

## Configuration
- USR_ROTATE_EN defined: all shifts rotate. Right shift feeds stage 0 into stage N−1; left shift feeds stage N−1 into stage 0. sr_in and sl_in are ignored.
- USR_ROTATE_EN undefined: shifts take sr_in/sl_in as above, and stages shifted out are discarded.

## Test plan
- Reset with N=8, W=1 → p_out=0, sr_out=0, busy_out=0, done_out=0. Assert reset asynchronously between edges → outputs clear immediately.
- Parallel load p_in=8'hA5 with en_in=1, mode 11 → p_out=8'hA5 next cycle. Then mode 01, sr_in=0, en_in=1 for 1 cycle → p_out=8'h52, sr_out=0.
- Serial fill: mode 01, sr_in sequence 1,0,1,1 then 0s → sr_out shows the first 1 exactly after 8 shifts. With en_in=0 for a cycle, the contents hold.
- Burst: load 8'h81, start_in=1, mode 10, cnt_in=3, sl_in=0 → busy_out high 3 cycles, done_out one pulse, p_out=8'h08. start_in during busy → ignored, p_out unchanged.
- cnt_in=0 burst → done_out pulses once, busy_out stays 0, p_out unchanged. Reset mid-burst (after 1 shift of 5) → IDLE, p_out=0, no done_out pulse.
- With USR_ROTATE_EN, W=4, N=4: load 16'h1234, burst right cnt_in=4 → p_out=16'h1234 after done_out. cnt_in=1 → p_out=16'h4123.
